// File: rtl/ratio_sin_pkg.sv
// ratio_sin_pkg: FSM states, default sizes and the quarter-wave sine generator
package ratio_sin_pkg;
  typedef enum logic [2:0] {IDLE, SUM, DIV, MUL, OUT} state_t;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_ANG_W = 10;
  localparam int DEF_SIN_W = 12;
  localparam int DEF_FRAC_W = 14;
  localparam int DEF_OUT_W = 12;
  localparam longint Q30 = 64'd1 << 30;
  localparam longint HALF_PI_Q30 = 64'd1686629713;
  // round(sin(pi/2 * k/qn) * amp) via a Q30 Taylor series; only ever called with constant arguments
  function automatic int qsin(input int k, input int qn, input int amp);
    longint x, t, s;
    x = HALF_PI_Q30 * longint'(k) / longint'(qn);
    t = x;
    s = x;
    for (int n = 1; n <= 9; n++) begin
      t = -((((t * x) / Q30) * x) / Q30) / longint'((2 * n) * (2 * n + 1));
      s += t;
    end
    return int'((s * longint'(amp) + Q30 / 2) / Q30);
  endfunction
endpackage

// File: rtl/ratio_sin_engine_divider.sv
// ratio_divider: restoring radix-2 divider, q = floor(num * 2^FRAC_W / den) in FRAC_W+1 cycles
module ratio_divider #(
  parameter int DATA_W = 12,
  parameter int FRAC_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] num,
  input  logic [DATA_W+1:0] den,
  output logic              done,
  output logic [FRAC_W:0]   q
);
  localparam int CW = $clog2(FRAC_W + 1);
  logic            busy;
  logic [CW-1:0]   cnt;
  logic [DATA_W+1:0] rem, dsr;
  logic [FRAC_W:0] bits;
  logic [DATA_W+2:0] trial;
  logic            ge;
  // num <= den, so the quotient fits FRAC_W+1 bits and num>>1 is a valid starting remainder
  assign trial = {rem, bits[FRAC_W]};
  assign ge = trial >= {1'b0, dsr};
  assign done = busy && cnt == CW'(FRAC_W);
  // one quotient bit per cycle; q holds its value after completion
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      dsr <= '0;
      bits <= '0;
      q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      rem <= (DATA_W + 2)'(num >> 1);
      dsr <= den;
      bits <= {num[0], {FRAC_W{1'b0}}};
      q <= '0;
    end else if (busy) begin
      rem <= ge ? (DATA_W + 2)'(trial - {1'b0, dsr}) : trial[DATA_W+1:0];
      q <= {q[FRAC_W-1:0], ge};
      bits <= bits << 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/ratio_sin_engine.sv
// ratio_sin_engine: y = sign(sin) * sat((a/(a+b+c)) * |sin(angle)|); RATIO_SIN_ROUND_EN selects round-half-up scaling
module ratio_sin_engine
  import ratio_sin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ANG_W = DEF_ANG_W,
  parameter int SIN_W = DEF_SIN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_en,
  input  logic              e,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y,
  output logic              err
);
  localparam int SW = DATA_W + 2;
  localparam int QN = 2 ** (ANG_W - 2);
  localparam int AMP = 2 ** SIN_W - 1;
  localparam int SH = FRAC_W + SIN_W - OUT_W + 1;
  localparam int PW = FRAC_W + 1 + SIN_W;
  localparam logic [PW:0] MAXM = (PW + 1)'((1 << (OUT_W - 1)) - 1);
  state_t              state;
  logic [ANG_W-1:0]    ang, ang_s;
  logic [DATA_W-1:0]   a_s, b_s, c_s;
  logic [SW-1:0]       s;
  logic [PW-1:0]       p;
  logic [PW:0]         pr, mw;
  logic [OUT_W-1:0]    m;
  logic [ANG_W-2:0]    idx;
  logic [SIN_W-1:0]    mag;
  logic [SIN_W-1:0]    qtab [0:QN];
  logic                div_done;
  logic [FRAC_W:0]     div_q;
  for (genvar i = 0; i <= QN; i++) begin : g_tab
    assign qtab[i] = SIN_W'(qsin(i, QN, AMP));
  end
  // second half-period mirrors the first: index wraps to 2*QN - r
  assign idx = ang_s[ANG_W-2] ? -ang_s[ANG_W-2:0] : ang_s[ANG_W-2:0];
  assign mag = qtab[idx];
  assign s = SW'(a_s) + SW'(b_s) + SW'(c_s);
`ifdef RATIO_SIN_ROUND_EN
  assign pr = {1'b0, p} + ((PW + 1)'(1) << (SH - 1));
`else
  assign pr = {1'b0, p};
`endif
  assign mw = pr >> SH;
  assign m = mw > MAXM ? OUT_W'(MAXM) : OUT_W'(mw);
  ratio_divider #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(state == SUM && s != '0),
    .num(a_s),
    .den(s),
    .done(div_done),
    .q(div_q)
  );
  // serial angle capture runs regardless of the transaction in flight
  always_ff @(posedge clk)
    if (!rst_n) ang <= '0;
    else if (ser_en) ang <= {ang[ANG_W-2:0], e};
  // transaction FSM; OUT spends its first cycle forming y before raising out_valid
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      y <= '0;
      err <= 1'b0;
      a_s <= '0;
      b_s <= '0;
      c_s <= '0;
      ang_s <= '0;
      p <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          a_s <= a;
          b_s <= b;
          c_s <= c;
          ang_s <= ang;
          in_ready <= 1'b0;
          state <= SUM;
        end
        SUM: begin
          err <= s == '0;
          state <= s == '0 ? MUL : DIV;
        end
        DIV: if (div_done) state <= MUL;
        MUL: begin
          p <= err ? '0 : PW'(div_q) * PW'(mag);
          state <= OUT;
        end
        OUT: if (!out_valid) begin
          y <= ang_s[ANG_W-1] ? -m : m;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ratio_sin_engine.sv
// tb_ratio_sin_engine: reference-model bench for ratio_sin_engine (directed + random)
module tb_ratio_sin_engine;
  localparam real PI = 3.14159265358979323846;
  logic clk = 0, rst_n = 0, ser_en = 0, e = 0, in_valid = 0, out_ready = 0;
  logic [11:0] a = 0, b = 0, c = 0;
  logic in_ready, out_valid, err;
  logic [11:0] y;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit mb = 0, mo = 0;
  int left = 0;
  logic [9:0] mang = 0;
  logic [11:0] ey = 0;
  logic eerr = 0;

  always #5 clk = ~clk;

  ratio_sin_engine dut (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .e(e), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // {err, y} straight from the arithmetic definition
  function automatic logic [12:0] model(input int av, input int bv, input int cv, input int ang);
    longint s, q, p, mm;
    int mag;
    real v;
    s = av + bv + cv;
    if (s == 0) return {1'b1, 12'd0};
    q = (longint'(av) << 14) / s;
    v = $sin(2.0 * PI * ang / 1024.0);
    if (v < 0.0) v = -v;
    mag = $rtoi(v * 4095.0 + 0.5);
    p = q * mag;
`ifdef RATIO_SIN_ROUND_EN
    mm = (p + 16384) >>> 15;
`else
    mm = p >>> 15;
`endif
    if (mm > 2047) mm = 2047;
    if (ang >= 512) mm = -mm;
    return {1'b0, 12'(mm)};
  endfunction

  // transaction-level model: idle / busy for a fixed latency / presenting a result
  always @(posedge clk) begin
    if (!rst_n) begin
      mb = 0;
      mo = 0;
      mang = 0;
    end else begin
      if (mo) mo = !out_ready;
      else if (mb) begin
        left--;
        if (left == 0) begin
          mb = 0;
          mo = 1;
        end
      end else if (in_valid) begin
        {eerr, ey} = model(a, b, c, mang);
        mb = 1;
        left = (int'(a) + int'(b) + int'(c) == 0) ? 3 : 18;
      end
      if (ser_en) mang = {mang[8:0], e};
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("in_ready", in_ready, !mb && !mo);
      chk("out_valid", out_valid, mo);
      if (mo) begin
        chk("y", y, ey);
        chk("err", err, eerr);
      end
    end

  task automatic load_ang(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      ser_en = 1;
      e = v[i];
    end
    @(negedge clk);
    ser_en = 0;
  endtask

  task automatic run(input int av, input int bv, input int cv, input int hold,
                     output int lat, output logic [11:0] yo, output logic eo);
    @(negedge clk);
    a = 12'(av);
    b = 12'(bv);
    c = 12'(cv);
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    yo = y;
    eo = err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = i[0];
      chk("hold_y", y, yo);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    int lat;
    logic [11:0] yo;
    logic eo;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    chk_en = 1;
    {eo, yo} = model(100, 100, 100, 256);
    chk("model_90", yo, 682);
    {eo, yo} = model(100, 100, 100, 768);
    chk("model_270", yo, 12'hD56);
    {eo, yo} = model(0, 0, 0, 5);
    chk("model_zero_err", eo, 1);
    load_ang(10'd256);
    run(100, 100, 100, 0, lat, yo, eo);
    chk("lat_90", lat, 18);
    chk("y_90", yo, 682);
    chk("err_90", eo, 0);
    load_ang(10'd768);
    run(100, 100, 100, 10, lat, yo, eo);
    chk("y_270", yo, 12'hD56);
    load_ang(10'd256);
    run(4095, 0, 0, 0, lat, yo, eo);
    chk("y_sat", yo, 2047);
    run(0, 0, 0, 0, lat, yo, eo);
    chk("lat_zero", lat, 3);
    chk("err_zero", eo, 1);
    chk("y_zero", yo, 0);
    @(negedge clk);
    a = 100; b = 100; c = 100; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    load_ang(10'd256);
    run(100, 100, 100, 0, lat, yo, eo);
    chk("post_rst_y", yo, 682);
    chk("post_rst_lat", lat, 18);
    repeat (4000) begin
      @(negedge clk);
      ser_en = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 599) != 0;
      if (!in_valid || $urandom_range(0, 1) == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: begin a = 12'($urandom_range(0, 2)); b = 12'($urandom_range(0, 2)); c = 12'($urandom_range(0, 2)); end
          1: begin a = 12'($urandom); b = 0; c = 12'($urandom_range(0, 1)); end
          default: begin a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); end
        endcase
      end
    end
    @(negedge clk);
    rst_n = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
